uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
- UART receive deserializer. Oversamples the asynchronous serial line, detects and validates start bits, shifts in 8N1 frames LSB-first, and checks the stop bit.
- Produces one write strobe per frame carrying {data, frame_error, break_error}. It sits directly upstream of the RX FIFO: data_valid drives the FIFO wr_en and the remaining outputs drive the FIFO data/error inputs.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
- DIV_W, 16, width of baud_div.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- baud_div  input  DIV_W  clk cycles per oversample tick, minus 1; quasi-static.
- rx_in  input  1  asynchronous serial line; idles high.
- data_out  output  DATA_WIDTH  received byte; valid when data_valid=1.
- frame_error  output  1  stop bit sampled low.
- break_error  output  1  all data bits and the stop bit sampled low.
- data_valid  output  1  one-cycle strobe per completed frame; drives FIFO wr_en.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - state=IDLE; tick, sample and bit counters 0; shift register 0.
  - Both synchronizer flops set to 1.
  - A reset mid-frame aborts the frame with no strobe.
- Synchronizer: rx_in passes through 2 flops; rxs is the synchronized value. All decisions use rxs only.
- Tick generator:
  - Free-running counter 0..baud_div; tick=1 on the cycle the counter equals baud_div, and the counter then reloads 0.
  - baud_div=0 gives a tick every clk.
- Sample counter (0..OVERSAMPLE-1) advances on ticks only.
- Majority vote: each bit is decided by a majority of rxs at samples M-1, M and M+1, where M=OVERSAMPLE/2. The decision is made at the M+1 tick.
- State machine (transitions occur on ticks only):
  - IDLE: a tick with rxs=0 moves to START with sample counter=0.
  - START: at decision, majority=1 is a glitch and returns to IDLE with no strobe. Otherwise stay until sample OVERSAMPLE-1, then go to DATA with bit counter=0.
  - DATA: at each decision, shift the majority bit in LSB-first. At sample OVERSAMPLE-1, go to STOP if the bit counter equals DATA_WIDTH-1, else increment the bit counter.
  - STOP: at decision, register the outputs, pulse data_valid, and move:
    - to BREAK_WAIT if break_error, else
    - to IDLE immediately (mid-stop-bit), so back-to-back frames resynchronize on the next falling edge.
  - BREAK_WAIT: a tick with rxs=1 returns to IDLE. A line held low produces no further strobes.
- Output register at STOP decision:
  - data_out = shift register.
  - frame_error = ~stop_majority.
  - break_error = ~stop_majority & (shift register == 0).
  - break_error=1 implies frame_error=1 and data_out=0.
  - data_out and both error flags hold until the next strobe.
- data_valid is high exactly one clk, in the cycle after the STOP-decision tick. It does not depend on FIFO full; drops are the FIFO's concern.
- Latency: the strobe is asserted 1 clk after tick number OVERSAMPLE*(DATA_WIDTH+1)+M+1 counted from the start-detect tick (tick 0). With the defaults this is tick 153.
- Stop-bit check is 1 stop bit only. There is no parity support.

Test Plan:
- Nominal frame: baud_div=0, send 0x55 (8N1, 16 clk/bit) -> exactly one data_valid pulse at clk 153+1 after start detect; data_out=0x55, frame_error=0, break_error=0, busy=0 afterwards.
- Start glitch: rx_in low for 4 ticks, then high -> no data_valid; busy high for <=9 ticks, then 0; a following 0x3C frame is received correctly.
- Framing error: send 0xA3 with the stop bit driven low for the full bit -> data_out=0xA3, frame_error=1, break_error=0; next frame 0x5A is clean.
- Break: rx_in low for 30 bit times, then high; then send 0x0F -> exactly one pulse with data_out=0x00, frame_error=1, break_error=1; busy stays 1 until rx returns high; next pulse gives 0x0F with no errors.
- Back-to-back with a single-sample glitch: baud_div=3, frames 0x00, 0xFF, 0x81 with no idle gap, plus a one-tick high spike at the middle of bit 2 of 0x00 -> three pulses with 0x00, 0xFF, 0x81 (majority rejects the spike), all error flags 0.
- Reset mid-frame: assert rst_n=0 during bit 4 of a frame -> all outputs 0 immediately, no strobe; after release, a fresh 0xC6 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_deser_if.sv
// Receive-side frame bundle between the UART deserializer and the RX FIFO write port.
interface uart_rx_deser_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_error;
  logic                  break_error;
  logic                  data_valid;
  logic                  busy;

  modport master (output data_out, frame_error, break_error, data_valid, busy);
  modport slave  (input  data_out, frame_error, break_error, data_valid, busy);
endinterface

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: oversampled, majority-voted, one write strobe per frame
// carrying the received byte with framing and break flags.
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx_in,
  uart_rx_deser_if.master  rx_if
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam int MID    = OVERSAMPLE / 2;

  localparam logic [SAMP_W-1:0] S_VOTE0  = SAMP_W'(MID - 1);
  localparam logic [SAMP_W-1:0] S_VOTE1  = SAMP_W'(MID);
  localparam logic [SAMP_W-1:0] S_DECIDE = SAMP_W'(MID + 1);
  localparam logic [SAMP_W-1:0] S_LAST   = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  B_LAST   = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t                state;
  logic                  sync_1;
  logic                  sync_2;
  logic                  rxs;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [SAMP_W-1:0]     samp_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [1:0]            votes;
  logic                  majority;
  logic                  decide;
  logic                  samp_last;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  shreg_zero;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  frame_err_q;
  logic                  break_err_q;
  logic                  valid_q;

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments so every flop samples
      // pre-edge values; a blocking write here would collapse the two sync stages into one.
      sync_1 <= rx_in;
      sync_2 <= sync_1;
    end
  end

  assign rxs = sync_2;

  // Comparing with >= lets the counter recover at once if baud_div is lowered.
  assign tick = (div_cnt >= baud_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // The two earlier votes are registered; the third is the live sample at the decision tick.
  assign majority   = (votes[0] & votes[1]) | (rxs & (votes[0] | votes[1]));
  assign decide     = (samp_cnt == S_DECIDE);
  assign samp_last  = (samp_cnt == S_LAST);
  assign shreg_zero = (shreg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      samp_cnt    <= '0;
      bit_cnt     <= '0;
      votes       <= '0;
      shreg       <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      break_err_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        if (state == S_START || state == S_DATA || state == S_STOP) begin
          if (samp_cnt == S_VOTE0) votes[0] <= rxs;
          if (samp_cnt == S_VOTE1) votes[1] <= rxs;
          samp_cnt <= samp_last ? '0 : samp_cnt + SAMP_W'(1);
        end

        case (state)
          S_IDLE: begin
            // The detecting tick is itself sample 0 of the start bit.
            if (!rxs) begin
              state    <= S_START;
              samp_cnt <= SAMP_W'(1);
            end
          end

          S_START: begin
            if (decide && majority) begin
              state <= S_IDLE;
            end else if (samp_last) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end

          S_DATA: begin
            if (decide) shreg <= {majority, shreg[DATA_WIDTH-1:1]};
            if (samp_last) begin
              if (bit_cnt == B_LAST) state   <= S_STOP;
              else                   bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end

          S_STOP: begin
            // Leaving mid-stop-bit lets a back-to-back start edge be caught on time.
            if (decide) begin
              data_q      <= shreg;
              frame_err_q <= ~majority;
              break_err_q <= ~majority & shreg_zero;
              valid_q     <= 1'b1;
              state       <= (~majority & shreg_zero) ? S_BREAK_WAIT : S_IDLE;
            end
          end

          S_BREAK_WAIT: begin
            if (rxs) state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_if.data_out    = data_q;
  assign rx_if.frame_error = frame_err_q;
  assign rx_if.break_error = break_err_q;
  assign rx_if.data_valid  = valid_q;
  assign rx_if.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: serial frames are driven bit by bit, expected
// {data, frame_error, break_error} are queued at drive time and popped on each strobe.
module tb_uart_rx_deser;

  localparam int DW    = 8;
  localparam int OS    = 16;
  localparam int CLK_P = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          fe;
    logic          be;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = '0;
  logic        rx_in = 1'b1;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  time  strobe_t = 0;
  time  start_t  = 0;

  uart_rx_deser_if #(.DATA_WIDTH(DW)) u_if ();

  uart_rx_deser #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS),
    .DIV_W     (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .baud_div(baud_div),
    .rx_in   (rx_in),
    .rx_if   (u_if.master)
  );

  always #(CLK_P / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && u_if.data_valid) begin
      strobes++;
      strobe_t = $time;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("data_out", 32'(u_if.data_out), 32'(mon_e.data));
        check("frame_error", 32'(u_if.frame_error), 32'(mon_e.fe));
        check("break_error", 32'(u_if.break_error), 32'(mon_e.be));
      end
    end
  end

  initial begin
    #(200000 * CLK_P);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic expect_frame(input logic [DW-1:0] d, input logic fe, input logic be);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  // One bit time on the line; spike=1 adds a one-tick high pulse in the middle of the bit.
  task automatic drive_bit(input logic b, input bit spike);
    int tick_clks = int'(baud_div) + 1;
    int n         = tick_clks * OS;
    rx_in = b;
    if (spike) begin
      repeat (n / 2) @(negedge clk);
      rx_in = 1'b1;
      repeat (tick_clks) @(negedge clk);
      rx_in = b;
      repeat (n - n / 2 - tick_clks) @(negedge clk);
    end else begin
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input int spike_bit);
    start_t = $time;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i], i == spike_bit);
    drive_bit(stop_bit, 1'b0);
    rx_in = 1'b1;
  endtask

  task automatic idle_bits(input int nbits);
    rx_in = 1'b1;
    repeat (nbits * (int'(baud_div) + 1) * OS) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_out"}, 32'(u_if.data_out), 32'd0);
    check({tag, "_frame_error"}, 32'(u_if.frame_error), 32'd0);
    check({tag, "_break_error"}, 32'(u_if.break_error), 32'd0);
    check({tag, "_data_valid"}, 32'(u_if.data_valid), 32'd0);
    check({tag, "_busy"}, 32'(u_if.busy), 32'd0);
  endtask

  initial begin
    int s0;
    int busy_cyc;
    logic [DW-1:0] mid_byte;

    rx_in    = 1'b1;
    baud_div = 16'd0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle_bits(2);

    // Nominal frame; strobe seen 2 sync clks + 1 detect clk + 153 ticks after the falling edge.
    s0 = strobes;
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, -1);
    wait_drain("nominal", 400);
    check("nominal_count", 32'(strobes - s0), 32'd1);
    check("nominal_latency", 32'((strobe_t - start_t) / CLK_P), 32'd156);
    idle_bits(1);
    check("nominal_busy_after", 32'(u_if.busy), 32'd0);

    // Start glitch: low for 4 ticks, rejected at the sample-9 decision.
    s0       = strobes;
    busy_cyc = 0;
    rx_in    = 1'b0;
    for (int k = 0; k < 44; k++) begin
      if (k == 4) rx_in = 1'b1;
      if (u_if.busy) busy_cyc++;
      @(negedge clk);
    end
    check("glitch_busy_cycles", 32'(busy_cyc), 32'd9);
    check("glitch_no_strobe", 32'(strobes - s0), 32'd0);
    check("glitch_busy_after", 32'(u_if.busy), 32'd0);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, -1);
    wait_drain("after_glitch", 400);

    // Framing error, then a clean frame.
    idle_bits(1);
    expect_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b0, -1);
    idle_bits(2);
    expect_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, -1);
    wait_drain("framing", 400);

    // Break: line low for 30 bit times yields exactly one break strobe.
    idle_bits(1);
    s0 = strobes;
    expect_frame(8'h00, 1'b1, 1'b1);
    rx_in = 1'b0;
    repeat (30 * OS) @(negedge clk);
    check("break_busy_held", 32'(u_if.busy), 32'd1);
    check("break_one_strobe", 32'(strobes - s0), 32'd1);
    rx_in = 1'b1;
    repeat (8) @(negedge clk);
    check("break_busy_released", 32'(u_if.busy), 32'd0);
    idle_bits(1);
    expect_frame(8'h0F, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, -1);
    wait_drain("after_break", 400);

    // Back-to-back frames at baud_div=3 with a one-tick spike mid data bit 2.
    idle_bits(1);
    baud_div = 16'd3;
    idle_bits(1);
    s0 = strobes;
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 2);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    idle_bits(1);
    wait_drain("b2b", 2000);
    check("b2b_count", 32'(strobes - s0), 32'd3);

    // Reset during data bit 4 aborts the frame with no strobe.
    baud_div = 16'd0;
    idle_bits(2);
    s0       = strobes;
    mid_byte = 8'hC6;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(mid_byte[i], 1'b0);
    rx_in = mid_byte[4];
    repeat (OS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    check("midreset_no_strobe", 32'(strobes - s0), 32'd0);
    expect_frame(8'hC6, 1'b0, 1'b0);
    send_frame(8'hC6, 1'b1, -1);
    wait_drain("after_reset", 400);
    idle_bits(1);

    check("total_strobes", 32'(strobes), 32'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
